// File: rtl/car_wave_sequencer.sv
// Car wave sequencer: spawns NUM_CARS car sprites by frame count, runs one draw pass
// per frame over a start/done handshake, and muxes the drawing car onto the VGA bus.
//
// state  | meaning
// IDLE   | waiting for start_frame
// SCAN   | testing car idx for eligibility, one car per cycle
// WAIT   | car idx drawing; waits for its done pulse or a timeout
// FINISH | pass over; raises frame_done and returns to IDLE
module car_wave_sequencer #(
   parameter int NUM_CARS  = 4,
   parameter int IDX_W     = 4,
   parameter int COORD_W   = 15,
   parameter int COLOUR_W  = 9,
   parameter int SPAWN_GAP = 30,
   parameter int TIMEOUT   = 4096
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         stage_active,
   input  logic [IDX_W-1:0]             active_cars,
   input  logic                         start_frame,
   input  logic [NUM_CARS-1:0]          destroyed_cars,
   input  logic [NUM_CARS-1:0]          car_draw_done,
   input  logic [NUM_CARS-1:0]          car_wren_in,
   input  logic [NUM_CARS*COORD_W-1:0]  car_coord_bus,
   input  logic [NUM_CARS*COLOUR_W-1:0] car_colour_bus,
   input  logic [NUM_CARS-1:0]          car_game_over,
   output logic [NUM_CARS-1:0]          car_initiate,
   output logic [NUM_CARS-1:0]          car_draw_start,
   output logic                         vga_wren,
   output logic [COORD_W-1:0]           vga_coord,
   output logic [COLOUR_W-1:0]          vga_colour,
   output logic                         frame_busy,
   output logic                         frame_done,
   output logic                         stage_car_done,
   output logic                         game_over_feedback,
   output logic                         draw_error
);

   localparam int FRAME_MAX = (NUM_CARS - 1) * SPAWN_GAP;
   localparam int FRAME_W   = (FRAME_MAX > 0) ? $clog2(FRAME_MAX + 1) : 1;
   localparam int TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [FRAME_W-1:0] FRAME_SAT = FRAME_W'(FRAME_MAX);
   localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CARS - 1);
   localparam logic [IDX_W-1:0]   CARS_SAT  = IDX_W'(NUM_CARS);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_FINISH} state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     count_q;
   logic [FRAME_W-1:0]   frame_cnt;
   logic [TMO_W-1:0]     tmo_cnt;
   logic                 stage_prev;
   logic                 stage_rise;
   logic                 all_destroyed;
   logic                 any_go;
   logic                 sel_elig;
   logic                 sel_done;
   logic                 sel_wren;
   logic [COORD_W-1:0]   sel_coord;
   logic [COLOUR_W-1:0]  sel_colour;
   logic [NUM_CARS-1:0]  idx_onehot;

   assign stage_rise = stage_active & ~stage_prev;
   assign frame_busy = (state != S_IDLE);

   always_comb begin
      car_initiate  = '0;
      all_destroyed = 1'b1;
      any_go        = 1'b0;
      for (int i = 0; i < NUM_CARS; i++) begin
         if (IDX_W'(i) < count_q) begin
            car_initiate[i] = stage_active && (int'(frame_cnt) >= i * SPAWN_GAP);
            if (!destroyed_cars[i]) all_destroyed = 1'b0;
            if (car_game_over[i]) any_go = 1'b1;
         end
      end
   end

   // Per-index selects via compare loop so idx never needs to match a vector's index width.
   always_comb begin
      sel_elig   = 1'b0;
      sel_done   = 1'b0;
      sel_wren   = 1'b0;
      sel_coord  = '0;
      sel_colour = '0;
      idx_onehot = '0;
      for (int i = 0; i < NUM_CARS; i++) begin
         if (idx == IDX_W'(i)) begin
            idx_onehot[i] = 1'b1;
            sel_elig   = car_initiate[i] & ~destroyed_cars[i];
            sel_done   = car_draw_done[i];
            sel_wren   = car_wren_in[i];
            sel_coord  = car_coord_bus[i*COORD_W +: COORD_W];
            sel_colour = car_colour_bus[i*COLOUR_W +: COLOUR_W];
         end
      end
   end

   assign vga_wren   = (state == S_WAIT) & sel_wren;
   assign vga_coord  = (state == S_WAIT) ? sel_coord : '0;
   assign vga_colour = (state == S_WAIT) ? sel_colour : '0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state              <= S_IDLE;
         idx                <= '0;
         count_q            <= '0;
         frame_cnt          <= '0;
         tmo_cnt            <= '0;
         stage_prev         <= 1'b0;
         car_draw_start     <= '0;
         frame_done         <= 1'b0;
         stage_car_done     <= 1'b0;
         game_over_feedback <= 1'b0;
         draw_error         <= 1'b0;
      end else begin
         stage_prev     <= stage_active;
         car_draw_start <= '0;
         frame_done     <= 1'b0;
         stage_car_done <= stage_active && (count_q != '0) && all_destroyed;

         if (stage_rise) begin
            count_q   <= (active_cars > CARS_SAT) ? CARS_SAT : active_cars;
            frame_cnt <= '0;
         end else if (frame_done && stage_active && frame_cnt != FRAME_SAT) begin
            frame_cnt <= frame_cnt + 1'b1;
         end

         if (stage_rise) game_over_feedback <= 1'b0;
         else if (stage_active && any_go) game_over_feedback <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start_frame) begin
                  state <= S_SCAN;
                  idx   <= '0;
               end
            end
            S_SCAN: begin
               if (sel_elig) begin
                  state          <= S_WAIT;
                  car_draw_start <= idx_onehot;
                  tmo_cnt        <= TMO_LOAD;
               end else if (idx == LAST_IDX) begin
                  state <= S_FINISH;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_WAIT: begin
               if (sel_done || tmo_cnt == '0) begin
                  if (!sel_done) draw_error <= 1'b1;
                  if (idx == LAST_IDX) begin
                     state <= S_FINISH;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_SCAN;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            S_FINISH: begin
               frame_done <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // A new stage wipes the previous stage's error even if a timeout lands now.
         if (stage_rise) draw_error <= 1'b0;
      end
   end

endmodule

// File: doc/car_wave_sequencer.md
Name: car_wave_sequencer

Overview:
Parametrised successor to the fixed four-car wave block. It manages NUM_CARS car sprite units per stage. Once per frame it sequences their draw cycles through an explicit start/done handshake, staggers car spawns by frame count, and muxes the active car's VGA write onto one bus. It also aggregates stage-complete and game-over status. It sits between the stage controller and the car sprite instances, and it feeds the shared VGA write arbiter.

Parameters:
NUM_CARS, 4, number of car units handled (1..16)
IDX_W, 4, index/count width; must satisfy 2**IDX_W >= NUM_CARS+1
COORD_W, 15, VGA coordinate width ({x[7:0], y[6:0]})
COLOUR_W, 9, VGA colour width
SPAWN_GAP, 30, frames between successive car spawns (car i spawns at frame i*SPAWN_GAP)
TIMEOUT, 4096, max cycles to wait for one car's draw_done before skipping it

Ports:
clk  in  1  system clock
resetn  in  1  active-low synchronous reset
stage_active  in  1  high while any stage is in progress; a rising edge starts a new wave
active_cars  in  IDX_W  number of cars used this stage (cars 0..active_cars-1); sampled on stage_active rising edge
start_frame  in  1  one-cycle request to draw all cars for this frame
destroyed_cars  in  NUM_CARS  per-car destroyed flags from lasers
car_draw_done  in  NUM_CARS  per-car draw-complete pulse
car_wren_in  in  NUM_CARS  per-car VGA write enable
car_coord_bus  in  NUM_CARS*COORD_W  packed coords; car i at [i*COORD_W +: COORD_W]
car_colour_bus  in  NUM_CARS*COLOUR_W  packed colours, packed the same way
car_game_over  in  NUM_CARS  per-car reached-end flag
car_initiate  out  NUM_CARS  level; car i spawned/enabled
car_draw_start  out  NUM_CARS  one-hot one-cycle draw request
vga_wren  out  1  muxed write enable
vga_coord  out  COORD_W  muxed coordinate
vga_colour  out  COLOUR_W  muxed colour
frame_busy  out  1  sequencer not IDLE
frame_done  out  1  one-cycle pulse when the frame's draw pass ends
stage_car_done  out  1  all active cars destroyed
game_over_feedback  out  1  sticky game over
draw_error  out  1  sticky; some car timed out

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, idx=0, frame counter=0, latched active count=0. All outputs are 0.
- Stage start: on the stage_active 0->1 edge (registered previous value), latch active_cars (saturated to NUM_CARS) and clear the frame counter, game_over_feedback and draw_error. The FSM is not disturbed.
- Frame counter: increments on each frame_done while stage_active. It saturates at its max; its width holds (NUM_CARS-1)*SPAWN_GAP.
- car_initiate[i] = stage_active & (i < latched count) & (frame_cnt >= i*SPAWN_GAP). Car 0 is therefore initiated the cycle after the stage starts.
- Eligible(i) = car_initiate[i] & ~destroyed_cars[i].
- FSM IDLE: on start_frame, go to SCAN with idx=0. start_frame is ignored in any other state.
- FSM SCAN: if eligible(idx), go to WAIT, pulse car_draw_start[idx] on the cycle WAIT is entered, and clear the timeout counter. Otherwise, if idx==NUM_CARS-1 go to FINISH, else idx++ and stay in SCAN. Each skipped car costs 1 cycle.
- FSM WAIT: on car_draw_done[idx], or when the timeout counter reaches TIMEOUT-1 (which also sets draw_error), advance: idx==NUM_CARS-1 goes to FINISH, else idx++ and go to SCAN. done from a non-selected car is ignored.
- FSM FINISH: frame_done=1 for this cycle, then go to IDLE.
- Mux: combinational. In WAIT, vga_wren=car_wren_in[idx] and coord/colour come from slice idx. Otherwise all three are 0. Other cars' wren is ignored, so there is no multi-driver priority.
- stage_car_done (registered): stage_active & latched count!=0 & all destroyed_cars[i] for i<count. A count of 0 gives 0.
- game_over_feedback: sets when any car_game_over[i] with i<count is seen while stage_active. It holds until reset or stage start. Stage start wins over a simultaneous set.
- stage_active falling mid-frame: the current pass completes normally. car_initiate drops, so the remaining cars are skipped.
- Worst-case pass with no draws: NUM_CARS+3 cycles from start_frame to frame_done.

Test Plan:
- NUM_CARS=4, SPAWN_GAP=2; stage start with active_cars=4; run frames with each car done 5 cycles after its start -> frames 0-1 draw car 0 only; frame 2 draws cars 0,1; frame 6 onward draws 0,1,2,3 in order; car_draw_start is one-hot.
- Same setup; destroyed_cars=4'b0101 after all cars have spawned -> each pass starts only cars 1 and 3. Set destroyed=4'b1111 -> stage_car_done=1 the next cycle, and a start_frame gives frame_done 7 cycles later with no starts.
- active_cars=2 -> car_initiate[3:2] stay 0 forever; car_game_over[3]=1 does not set game_over_feedback; car_game_over[1]=1 sets it; the next stage start clears it.
- TIMEOUT=16; car 1 never asserts done -> after 16 WAIT cycles draw_error=1, car 2 is started, and frame_done still pulses.
- During WAIT on car 2, pulse car_wren_in=4'b0110 with distinct coords -> vga_coord equals car 2's slice. A second start_frame mid-pass is ignored, giving exactly one frame_done.
- Assert resetn=0 mid-WAIT -> the next cycle shows all outputs 0 and state IDLE; start_frame after release restarts from car 0.
